i2c_start_stop_detector: RTL and testbench
==========================================

# i2c_start_stop_detector

Front end of the I2C master's bus monitor. It synchronizes the raw SCL and SDA pad inputs and removes glitches from both lines. It then detects START and STOP conditions and emits single-cycle `start_detected` and `stop_detected` pulses, which drive the bus busy detector directly. It also exports the filtered lines and SCL edge pulses for the bit-level engines.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth per line. Minimum 2.
- `FILTER_CYCLES`, default 4: consecutive stable cycles required before a filtered line changes. Minimum 1.

Ports:
- `clk`  input  1  block clock.
- `resetn`  input  1  reset, asynchronous, active-low.
- `scl_in`  input  1  raw SCL pad input, asynchronous to `clk`.
- `sda_in`  input  1  raw SDA pad input, asynchronous to `clk`.
- `detect_en`  input  1  enables event generation. When it is 0, no pulses are produced.
- `scl_filt`  output  1  filtered SCL.
- `sda_filt`  output  1  filtered SDA.
- `scl_rise`  output  1  one-cycle pulse on a filtered SCL 0→1 transition.
- `scl_fall`  output  1  one-cycle pulse on a filtered SCL 1→0 transition.
- `start_detected`  output  1  one-cycle START pulse.
- `stop_detected`  output  1  one-cycle STOP pulse.
- `bus_busy_detector_flop_en`  output  1  `detect_en & armed`. This is the enable for the downstream busy flop.
- `armed`  output  1  the detector has seen an idle bus since reset.

## Operation
- Synchronizer: a chain of `SYNC_STAGES` flops per line, all resetting to 1. The last stage is `scl_sync` / `sda_sync`.
- Glitch filter, per line:
  - Counter `cnt` of width $clog2(FILTER_CYCLES+1).
  - When `sync == filt`, `cnt` is set to 0.
  - Otherwise `cnt` increments. On the cycle where `cnt == FILTER_CYCLES-1` and the mismatch persists, `filt` takes `sync` and `cnt` clears.
  - `filt` resets to 1 and `cnt` resets to 0.
- Previous-value flops `scl_q` / `sda_q` hold the last cycle's `filt` values and reset to 1.
- Event terms, evaluated combinationally from the current and previous filtered values:
  - START = `scl_q & scl_filt & sda_q & ~sda_filt`.
  - STOP = `scl_q & scl_filt & ~sda_q & sda_filt`.
  - Both require SCL high in both cycles. If SCL and SDA change on the same filtered cycle, neither event fires.
  - START and STOP are mutually exclusive by construction. Both outputs must never be high together.
- Arming:
  - `armed` resets to 0.
  - It sets once `scl_filt & sda_filt` has held for FILTER_CYCLES consecutive cycles, using a third counter.
  - Once set, it stays set until reset.
  - While `armed` is 0, START, STOP, `scl_rise` and `scl_fall` are all suppressed. This prevents false events when reset releases mid-transaction.
- Output registers:
  - `start_detected = START & armed & detect_en`, registered.
  - `stop_detected` is formed the same way from STOP.
  - `scl_rise` / `scl_fall` are the registered SCL edge terms, gated by `armed` only.
  - All four reset to 0.
- Deasserting `detect_en` suppresses new START/STOP pulses from the next edge. It does not alter filter or arming state.

## Timing
- A change at the `scl_sync` / `sda_sync` output propagates as follows:
  - The filtered output changes FILTER_CYCLES edges after the change first appears at the sync output.
  - The event pulse appears one edge after that.
  - Total from the first sampling edge of the pad change: SYNC_STAGES + FILTER_CYCLES + 1 edges. With defaults this is 7.
- A pulse on the sync output shorter than FILTER_CYCLES cycles never reaches `filt`.
- All event outputs are high for exactly one cycle per condition.
- Reset values: `scl_filt`=1, `sda_filt`=1, all pulses 0, `armed`=0, `bus_busy_detector_flop_en`=0.
- Asserting `resetn` at any point returns every flop to its reset value immediately. Arming restarts after reset releases.

## Structure
- Shared package `i2c_pkg`:
  - Default constants `I2C_SYNC_STAGES` and `I2C_FILTER_CYCLES`.
  - An `i2c_line_t` struct (`scl`, `sda`) for the filtered-line bundle.
- Sub-module `i2c_line_filter`: synchronizer plus glitch filter for one line, instantiated twice. It is built on the existing `dff` cell.
- Edge/event logic and arming live in the top level.

## Test plan
- START: reset, hold both lines at 1 for 20 cycles, then drop `sda_in` with SCL=1 → `armed`=1, and exactly one `start_detected` pulse 7 cycles after the first sampling edge of the SDA fall. `stop_detected` stays 0.
- STOP: with SCL=1, raise `sda_in` → exactly one `stop_detected` pulse after 7 cycles. `start_detected` stays 0.
- Glitch: 3-cycle low pulse on `sda_in` with SCL=1 → `sda_filt` stays 1 and no events fire. A 4-cycle pulse → START, then STOP.
- Simultaneous: toggle `scl_in` and `sda_in` on the same edge → no START/STOP, and one `scl_fall` (or `scl_rise`) pulse.
- Reset mid-transaction: reset released with SCL=1, SDA=0 → no START. `armed`=0 until both lines are held high for 4 cycles.
- `detect_en`=0 during a START → no `start_detected`, `bus_busy_detector_flop_en`=0, while `scl_filt` / `sda_filt` still track the lines.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared constants and types for the I2C master bus-monitor front end.
package i2c_pkg;

    localparam int I2C_SYNC_STAGES   = 2;
    localparam int I2C_FILTER_CYCLES = 4;

    typedef struct packed {
        logic scl;
        logic sda;
    } i2c_line_t;

    // Width of a counter that must reach FILTER_CYCLES-1; never narrower than one bit.
    function automatic int filt_cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/dff.sv
// Resettable D flip-flop cell with asynchronous active-low reset and a configurable reset value.
module dff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= RST_VAL;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/i2c_line_filter.sv
// One I2C line: metastability synchronizer followed by a stable-count glitch filter.
module i2c_line_filter
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES   = I2C_SYNC_STAGES,
    parameter int FILTER_CYCLES = I2C_FILTER_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_line,
    output logic o_filt,
    output logic o_pend
);

    localparam int              CW       = filt_cnt_width(FILTER_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] w_sync_q;
    logic [SYNC_STAGES-1:0] w_sync_d;
    logic                   w_sync;
    logic                   w_filt_q;
    logic                   w_filt_d;
    logic [CW-1:0]          w_cnt_q;
    logic [CW-1:0]          w_cnt_d;

    // Idle I2C lines are pulled high, so every stage resets to 1.
    assign w_sync_d = {w_sync_q[SYNC_STAGES-2:0], i_line};
    assign w_sync   = w_sync_q[SYNC_STAGES-1];

    dff #(
        .WIDTH   (SYNC_STAGES),
        .RST_VAL ('1)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (w_sync_d),
        .o_q     (w_sync_q)
    );

    always_comb begin
        w_filt_d = w_filt_q;
        w_cnt_d  = '0;
        if (w_sync != w_filt_q) begin
            if (w_cnt_q == CNT_LAST) begin
                w_filt_d = w_sync;
            end else begin
                w_cnt_d = w_cnt_q + 1'b1;
            end
        end
    end

    dff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_filt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (w_filt_d),
        .o_q     (w_filt_q)
    );

    dff #(
        .WIDTH   (CW),
        .RST_VAL ('0)
    ) u_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (w_cnt_d),
        .o_q     (w_cnt_q)
    );

    assign o_filt = w_filt_q;
    assign o_pend = (w_sync != w_filt_q);

endmodule

// File: rtl/i2c_start_stop_detector.sv
// Bus-monitor front end: filters SCL/SDA, arms on an idle bus and emits START/STOP and SCL edge pulses.
module i2c_start_stop_detector
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES   = I2C_SYNC_STAGES,
    parameter int FILTER_CYCLES = I2C_FILTER_CYCLES
) (
    input  logic clk,
    input  logic resetn,
    input  logic scl_in,
    input  logic sda_in,
    input  logic detect_en,
    output logic scl_filt,
    output logic sda_filt,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_detected,
    output logic stop_detected,
    output logic bus_busy_detector_flop_en,
    output logic armed
);

    localparam int            CW       = filt_cnt_width(FILTER_CYCLES);
    localparam logic [CW-1:0] ARM_LAST = CW'(FILTER_CYCLES - 1);

    i2c_line_t     w_filt;
    i2c_line_t     r_prev;
    logic          w_scl_pend;
    logic          w_sda_pend;
    logic          w_start;
    logic          w_stop;
    logic          w_rise;
    logic          w_fall;
    logic          w_idle;
    logic [CW-1:0] r_arm_cnt;
    logic          r_armed;
    logic          r_start;
    logic          r_stop;
    logic          r_rise;
    logic          r_fall;

    i2c_line_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_scl (
        .i_clk   (clk),
        .i_rst_n (resetn),
        .i_line  (scl_in),
        .o_filt  (w_filt.scl),
        .o_pend  (w_scl_pend)
    );

    i2c_line_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_sda (
        .i_clk   (clk),
        .i_rst_n (resetn),
        .i_line  (sda_in),
        .o_filt  (w_filt.sda),
        .o_pend  (w_sda_pend)
    );

    assign w_start = r_prev.scl & w_filt.scl & r_prev.sda & ~w_filt.sda;
    assign w_stop  = r_prev.scl & w_filt.scl & ~r_prev.sda & w_filt.sda;
    assign w_rise  = ~r_prev.scl & w_filt.scl;
    assign w_fall  = r_prev.scl & ~w_filt.scl;

    // Filtered lines reset high, so a change already queued in a filter (e.g. SDA held low
    // across reset) must also break the idle run; otherwise we could arm just before it lands.
    assign w_idle  = w_filt.scl & w_filt.sda & ~w_scl_pend & ~w_sda_pend;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_prev    <= '1;
            r_arm_cnt <= '0;
            r_armed   <= 1'b0;
            r_start   <= 1'b0;
            r_stop    <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
        end else begin
            r_prev <= w_filt;
            if (!r_armed) begin
                if (!w_idle) begin
                    r_arm_cnt <= '0;
                end else if (r_arm_cnt == ARM_LAST) begin
                    r_armed   <= 1'b1;
                    r_arm_cnt <= '0;
                end else begin
                    r_arm_cnt <= r_arm_cnt + 1'b1;
                end
            end
            r_start <= w_start & r_armed & detect_en;
            r_stop  <= w_stop & r_armed & detect_en;
            r_rise  <= w_rise & r_armed;
            r_fall  <= w_fall & r_armed;
        end
    end

    assign scl_filt                  = w_filt.scl;
    assign sda_filt                  = w_filt.sda;
    assign scl_rise                  = r_rise;
    assign scl_fall                  = r_fall;
    assign start_detected            = r_start;
    assign stop_detected             = r_stop;
    assign armed                     = r_armed;
    assign bus_busy_detector_flop_en = detect_en & r_armed;

endmodule

// File: tb/tb_i2c_start_stop_detector.sv
// Directed bench for i2c_start_stop_detector with default parameters (2 sync stages, 4 filter cycles).
module tb_i2c_start_stop_detector;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic scl_in = 1'b1;
    logic sda_in = 1'b1;
    logic detect_en = 1'b1;
    logic scl_filt;
    logic sda_filt;
    logic scl_rise;
    logic scl_fall;
    logic start_detected;
    logic stop_detected;
    logic bus_busy_detector_flop_en;
    logic armed;

    int n_pass  = 0;
    int n_total = 0;
    int n_start = 0;
    int n_stop  = 0;
    int n_rise  = 0;
    int n_fall  = 0;
    int n_both  = 0;

    int s_start;
    int s_stop;
    int s_rise;
    int s_fall;
    logic low_seen;

    i2c_start_stop_detector #(
        .SYNC_STAGES   (2),
        .FILTER_CYCLES (4)
    ) dut (
        .clk                       (clk),
        .resetn                    (resetn),
        .scl_in                    (scl_in),
        .sda_in                    (sda_in),
        .detect_en                 (detect_en),
        .scl_filt                  (scl_filt),
        .sda_filt                  (sda_filt),
        .scl_rise                  (scl_rise),
        .scl_fall                  (scl_fall),
        .start_detected            (start_detected),
        .stop_detected             (stop_detected),
        .bus_busy_detector_flop_en (bus_busy_detector_flop_en),
        .armed                     (armed)
    );

    always #5 clk = ~clk;

    // Pulse tallies sampled mid-cycle, so each one-cycle pulse is counted once.
    always @(negedge clk) begin
        if (start_detected) n_start++;
        if (stop_detected) n_stop++;
        if (scl_rise) n_rise++;
        if (scl_fall) n_fall++;
        if (start_detected && stop_detected) n_both++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic snap();
        s_start = n_start;
        s_stop  = n_stop;
        s_rise  = n_rise;
        s_fall  = n_fall;
    endtask

    initial begin
        // Reset values
        tick(2);
        check("rst_scl_filt", 32'(scl_filt), 1);
        check("rst_sda_filt", 32'(sda_filt), 1);
        check("rst_start", 32'(start_detected), 0);
        check("rst_stop", 32'(stop_detected), 0);
        check("rst_rise", 32'(scl_rise), 0);
        check("rst_fall", 32'(scl_fall), 0);
        check("rst_armed", 32'(armed), 0);
        check("rst_flop_en", 32'(bus_busy_detector_flop_en), 0);

        // Arming after 4 idle cycles
        resetn = 1'b1;
        tick(3);
        check("arm_not_yet", 32'(armed), 0);
        tick(1);
        check("arm_set", 32'(armed), 1);
        check("arm_flop_en", 32'(bus_busy_detector_flop_en), 1);
        tick(16);

        // START: SDA falls with SCL high, pulse at edge 7
        snap();
        sda_in = 1'b0;
        tick(5);
        check("start_sda_filt_e5", 32'(sda_filt), 1);
        tick(1);
        check("start_sda_filt_e6", 32'(sda_filt), 0);
        check("start_e6", 32'(start_detected), 0);
        tick(1);
        check("start_e7", 32'(start_detected), 1);
        check("start_e7_stop", 32'(stop_detected), 0);
        tick(1);
        check("start_e8", 32'(start_detected), 0);
        tick(5);
        check("start_count", 32'(n_start - s_start), 1);
        check("start_stop_count", 32'(n_stop - s_stop), 0);

        // STOP: SDA rises with SCL high
        snap();
        sda_in = 1'b1;
        tick(6);
        check("stop_e6", 32'(stop_detected), 0);
        tick(1);
        check("stop_e7", 32'(stop_detected), 1);
        check("stop_e7_start", 32'(start_detected), 0);
        tick(6);
        check("stop_count", 32'(n_stop - s_stop), 1);
        check("stop_start_count", 32'(n_start - s_start), 0);

        // 3-cycle glitch is swallowed
        snap();
        sda_in = 1'b0;
        tick(3);
        sda_in = 1'b1;
        low_seen = 1'b0;
        repeat (12) begin
            tick(1);
            if (!sda_filt) low_seen = 1'b1;
        end
        check("glitch3_sda_low", 32'(low_seen), 0);
        check("glitch3_start", 32'(n_start - s_start), 0);
        check("glitch3_stop", 32'(n_stop - s_stop), 0);

        // 4-cycle pulse passes: START then STOP
        snap();
        sda_in = 1'b0;
        tick(4);
        sda_in = 1'b1;
        tick(2);
        check("glitch4_sda_filt", 32'(sda_filt), 0);
        tick(1);
        check("glitch4_start_pulse", 32'(start_detected), 1);
        tick(10);
        check("glitch4_start", 32'(n_start - s_start), 1);
        check("glitch4_stop", 32'(n_stop - s_stop), 1);

        // Simultaneous SCL/SDA changes: edges only, no START/STOP
        snap();
        scl_in = 1'b0;
        sda_in = 1'b0;
        tick(6);
        check("simul_scl_filt", 32'(scl_filt), 0);
        check("simul_sda_filt", 32'(sda_filt), 0);
        tick(1);
        check("simul_fall_pulse", 32'(scl_fall), 1);
        check("simul_fall_start", 32'(start_detected), 0);
        tick(5);
        scl_in = 1'b1;
        sda_in = 1'b1;
        tick(7);
        check("simul_rise_pulse", 32'(scl_rise), 1);
        check("simul_rise_stop", 32'(stop_detected), 0);
        tick(5);
        check("simul_fall_count", 32'(n_fall - s_fall), 1);
        check("simul_rise_count", 32'(n_rise - s_rise), 1);
        check("simul_start_count", 32'(n_start - s_start), 0);
        check("simul_stop_count", 32'(n_stop - s_stop), 0);

        // Reset released mid-transaction (SCL=1, SDA=0)
        sda_in = 1'b0;
        resetn = 1'b0;
        #1;
        check("midrst_armed", 32'(armed), 0);
        check("midrst_sda_filt", 32'(sda_filt), 1);
        check("midrst_flop_en", 32'(bus_busy_detector_flop_en), 0);
        tick(1);
        resetn = 1'b1;
        snap();
        tick(15);
        check("midrst_armed_low", 32'(armed), 0);
        check("midrst_sda_tracks", 32'(sda_filt), 0);
        sda_in = 1'b1;
        tick(9);
        check("midrst_armed_e9", 32'(armed), 0);
        check("midrst_sda_high", 32'(sda_filt), 1);
        tick(1);
        check("midrst_armed_e10", 32'(armed), 1);
        tick(3);
        check("midrst_start", 32'(n_start - s_start), 0);
        check("midrst_stop", 32'(n_stop - s_stop), 0);

        // detect_en low during a START
        detect_en = 1'b0;
        #1;
        check("den_flop_en", 32'(bus_busy_detector_flop_en), 0);
        snap();
        sda_in = 1'b0;
        tick(6);
        check("den_sda_filt_low", 32'(sda_filt), 0);
        tick(1);
        check("den_start_pulse", 32'(start_detected), 0);
        check("den_armed", 32'(armed), 1);
        tick(4);
        sda_in = 1'b1;
        tick(10);
        check("den_sda_filt_high", 32'(sda_filt), 1);
        check("den_start", 32'(n_start - s_start), 0);
        check("den_stop", 32'(n_stop - s_stop), 0);
        detect_en = 1'b1;
        #1;
        check("den_flop_en_back", 32'(bus_busy_detector_flop_en), 1);

        check("never_both", 32'(n_both), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
